// File: rtl/wb_port_arbiter.sv
// Merges two retiring lanes onto one register-file write port in program order through a
// pending queue; outputs are one edge after acceptance; stall holds upstream when the queue nears full.
module wb_port_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       regwrite_in1,
  input  logic                       memtoreg_in1,
  input  logic [7:0]                 readdata_in1,
  input  logic [7:0]                 resultalu_in1,
  input  logic [4:0]                 rd_in1,
  input  logic                       regwrite_in2,
  input  logic                       memtoreg_in2,
  input  logic [7:0]                 readdata_in2,
  input  logic [7:0]                 resultalu_in2,
  input  logic [4:0]                 rd_in2,
  output logic                       stall,
  output logic                       rf_we,
  output logic [4:0]                 rf_waddr,
  output logic [7:0]                 rf_wdata,
  input  logic [4:0]                 lk_addr,
  output logic                       lk_hit,
  output logic [7:0]                 lk_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [4:0] addr;
    logic [7:0] data;
  } wb_entry_t;

  wb_entry_t       q_q [DEPTH];
  wb_entry_t       q_d [DEPTH];
  logic [OW-1:0]   occ_q, occ_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_waddr_q, rf_waddr_d;
  logic [7:0]      rf_wdata_q, rf_wdata_d;

  logic            v1, v2, take1, take2;
  wb_entry_t       c1, c2, cand_a;
  wb_entry_t       s [DEPTH+1];
  int              occ_int, ncand, total;

  assign stall     = (occ_q >= OW'(DEPTH-1));
  assign occupancy = occ_q;
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;

  always_comb begin
    v1      = regwrite_in1 && (rd_in1 != 5'd0);
    v2      = regwrite_in2 && (rd_in2 != 5'd0);
    // on a same-register collision only the younger lane survives
    take1   = !stall && v1 && !(v2 && (rd_in1 == rd_in2));
    take2   = !stall && v2;
    c1      = '{addr: rd_in1, data: memtoreg_in1 ? readdata_in1 : resultalu_in1};
    c2      = '{addr: rd_in2, data: memtoreg_in2 ? readdata_in2 : resultalu_in2};
    cand_a  = take1 ? c1 : c2;
    ncand   = int'(take1) + int'(take2);
    occ_int = int'(occ_q);
    total   = occ_int + ncand;

    // stream = queued entries oldest first, then accepted lanes
    for (int i = 0; i < DEPTH + 1; i++) begin
      s[i] = '0;
      if (i < DEPTH && i < occ_int) s[i] = q_q[i < DEPTH ? i : 0];
      if (i == occ_int && ncand >= 1) s[i] = cand_a;
      if (i == occ_int + 1 && ncand == 2) s[i] = c2;
    end

    rf_we_d    = (total > 0);
    rf_waddr_d = (total > 0) ? s[0].addr : 5'd0;
    rf_wdata_d = (total > 0) ? s[0].data : 8'd0;
    for (int i = 0; i < DEPTH; i++) q_d[i] = s[i+1];
    occ_d = (total > 0) ? OW'(total - 1) : '0;
  end

  // youngest match wins: later queue slots override the head and the output register
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = 8'd0;
    if (lk_addr != 5'd0) begin
      if (rf_we_q && rf_waddr_q == lk_addr) begin
        lk_hit  = 1'b1;
        lk_data = rf_wdata_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (i < occ_int && q_q[i].addr == lk_addr) begin
          lk_hit  = 1'b1;
          lk_data = q_q[i].data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= 8'd0;
      for (int i = 0; i < DEPTH; i++) q_q[i] <= '0;
    end else begin
      occ_q      <= occ_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      for (int i = 0; i < DEPTH; i++) q_q[i] <= q_d[i];
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with DEPTH=4.
module tb_wb_port_arbiter;

  logic       clk;
  logic       reset;
  logic       regwrite_in1, memtoreg_in1, regwrite_in2, memtoreg_in2;
  logic [7:0] readdata_in1, resultalu_in1, readdata_in2, resultalu_in2;
  logic [4:0] rd_in1, rd_in2;
  logic       stall, rf_we, lk_hit;
  logic [4:0] rf_waddr, lk_addr;
  logic [7:0] rf_wdata, lk_data;
  logic [2:0] occupancy;

  int checks = 0;
  int errors = 0;

  wb_port_arbiter #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .regwrite_in1(regwrite_in1), .memtoreg_in1(memtoreg_in1),
    .readdata_in1(readdata_in1), .resultalu_in1(resultalu_in1), .rd_in1(rd_in1),
    .regwrite_in2(regwrite_in2), .memtoreg_in2(memtoreg_in2),
    .readdata_in2(readdata_in2), .resultalu_in2(resultalu_in2), .rd_in2(rd_in2),
    .stall(stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_data(lk_data), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lane1(input logic we, input logic m2r, input logic [7:0] rdat,
                       input logic [7:0] alu, input logic [4:0] rd);
    regwrite_in1 = we; memtoreg_in1 = m2r; readdata_in1 = rdat; resultalu_in1 = alu; rd_in1 = rd;
  endtask

  task automatic lane2(input logic we, input logic m2r, input logic [7:0] rdat,
                       input logic [7:0] alu, input logic [4:0] rd);
    regwrite_in2 = we; memtoreg_in2 = m2r; readdata_in2 = rdat; resultalu_in2 = alu; rd_in2 = rd;
  endtask

  task automatic idle();
    lane1(1'b0, 1'b0, 8'h00, 8'h00, 5'd0);
    lane2(1'b0, 1'b0, 8'h00, 8'h00, 5'd0);
  endtask

  task automatic test_reset();
    reset = 1'b0; lk_addr = 5'd0; idle();
    #2;
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ got %0d want 0", occupancy); end
    checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 8'd0) begin errors++;
      $display("FAIL reset_rf got we=%b a=%0d d=%h want 0/0/00", rf_we, rf_waddr, rf_wdata); end
    checks++; if (stall !== 1'b0 || lk_hit !== 1'b0 || lk_data !== 8'd0) begin errors++;
      $display("FAIL reset_misc got stall=%b hit=%b data=%h want 0/0/00", stall, lk_hit, lk_data); end
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_single();
    lane1(1'b1, 1'b1, 8'hA5, 8'h11, 5'd5);
    tick(); idle();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 8'hA5) begin errors++;
      $display("FAIL single_rf got we=%b a=%0d d=%h want 1/5/a5", rf_we, rf_waddr, rf_wdata); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL single_occ got %0d want 0", occupancy); end
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL single_idle got we=%b want 0", rf_we); end
  endtask

  task automatic test_dual();
    lane1(1'b1, 1'b0, 8'h99, 8'h10, 5'd3);
    lane2(1'b1, 1'b0, 8'h99, 8'h20, 5'd4);
    tick(); idle();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 8'h10) begin errors++;
      $display("FAIL dual_first got we=%b a=%0d d=%h want 1/3/10", rf_we, rf_waddr, rf_wdata); end
    checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL dual_occ1 got %0d want 1", occupancy); end
    lk_addr = 5'd4; #1;
    checks++; if (lk_hit !== 1'b1 || lk_data !== 8'h20) begin errors++;
      $display("FAIL dual_lk_queue got hit=%b d=%h want 1/20", lk_hit, lk_data); end
    lk_addr = 5'd3; #1;
    checks++; if (lk_hit !== 1'b1 || lk_data !== 8'h10) begin errors++;
      $display("FAIL dual_lk_rf got hit=%b d=%h want 1/10", lk_hit, lk_data); end
    lk_addr = 5'd9; #1;
    checks++; if (lk_hit !== 1'b0 || lk_data !== 8'h00) begin errors++;
      $display("FAIL dual_lk_miss got hit=%b d=%h want 0/00", lk_hit, lk_data); end
    tick();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 8'h20) begin errors++;
      $display("FAIL dual_second got we=%b a=%0d d=%h want 1/4/20", rf_we, rf_waddr, rf_wdata); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL dual_occ0 got %0d want 0", occupancy); end
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL dual_idle got we=%b want 0", rf_we); end
  endtask

  task automatic test_collision();
    lane1(1'b1, 1'b0, 8'h00, 8'h01, 5'd7);
    lane2(1'b1, 1'b0, 8'h00, 8'h02, 5'd7);
    tick(); idle();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 8'h02) begin errors++;
      $display("FAIL coll_rf got we=%b a=%0d d=%h want 1/7/02", rf_we, rf_waddr, rf_wdata); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL coll_occ got %0d want 0", occupancy); end
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL coll_single got we=%b want 0", rf_we); end
  endtask

  task automatic test_r0();
    lane1(1'b1, 1'b0, 8'h00, 8'hFF, 5'd0);
    tick(); idle();
    lk_addr = 5'd0; #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL r0_we got %b want 0", rf_we); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL r0_occ got %0d want 0", occupancy); end
    checks++; if (lk_hit !== 1'b0) begin errors++; $display("FAIL r0_lk got hit=%b want 0", lk_hit); end
  endtask

  task automatic test_stall();
    // occupancy after each edge, hand-derived for five back-to-back dual writes
    int exp_occ [12] = '{0, 1, 2, 3, 2, 3, 2, 3, 2, 1, 0, 0};
    logic [12:0] sb [$];
    logic [12:0] exp_e;
    int k = 0;
    for (int e = 1; e <= 11; e++) begin
      bit stalled = (exp_occ[e-1] >= 3);
      bit accepted = !stalled && (k < 5);
      if (k < 5) begin
        lane1(1'b1, 1'b0, 8'hEE, 8'(8'h30 + k), 5'(8 + 2*k));
        lane2(1'b1, 1'b1, 8'(8'h40 + k), 8'hEE, 5'(9 + 2*k));
      end else idle();
      if (accepted) begin
        sb.push_back({5'(8 + 2*k), 8'(8'h30 + k)});
        sb.push_back({5'(9 + 2*k), 8'(8'h40 + k)});
      end
      tick();
      if (sb.size() > 0) begin
        exp_e = sb.pop_front();
        checks++; if (rf_we !== 1'b1 || {rf_waddr, rf_wdata} !== exp_e) begin errors++;
          $display("FAIL stall_wr e%0d got we=%b a=%0d d=%h want 1/%0d/%h", e, rf_we, rf_waddr, rf_wdata, exp_e[12:8], exp_e[7:0]); end
      end else begin
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL stall_end e%0d got we=%b want 0", e, rf_we); end
      end
      checks++; if (occupancy !== 3'(exp_occ[e])) begin errors++;
        $display("FAIL stall_occ e%0d got %0d want %0d", e, occupancy, exp_occ[e]); end
      checks++; if (stall !== (exp_occ[e] >= 3)) begin errors++;
        $display("FAIL stall_sig e%0d got %b want %b", e, stall, exp_occ[e] >= 3); end
      if (accepted) k++;
    end
    idle();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      lane1(1'b1, 1'b0, 8'h00, 8'(8'h50 + i), 5'(20 + 2*i));
      lane2(1'b1, 1'b0, 8'h00, 8'(8'h60 + i), 5'(21 + 2*i));
      tick();
    end
    idle();
    checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL rmid_fill got %0d want 3", occupancy); end
    @(negedge clk);
    lk_addr = 5'd25;
    reset = 1'b0; #1;
    checks++; if (occupancy !== 3'd0 || rf_we !== 1'b0 || stall !== 1'b0) begin errors++;
      $display("FAIL rmid_async got occ=%0d we=%b stall=%b want 0/0/0", occupancy, rf_we, stall); end
    checks++; if (lk_hit !== 1'b0) begin errors++; $display("FAIL rmid_lk got hit=%b want 0", lk_hit); end
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (rf_we !== 1'b0 || occupancy !== 3'd0) begin errors++;
        $display("FAIL rmid_after c%0d got we=%b occ=%0d want 0/0", i, rf_we, occupancy); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_dual();
    test_collision();
    test_r0();
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Write-back port arbiter for the dual-issue 8-bit pipeline. It sits between the MEM/WB pipeline register and the register file. It merges the two retiring lanes onto the register file's single write port, in program order, using a small pending-write queue. It stalls the upstream pipeline when the queue would overflow and exposes a lookup port so the decode stage can forward values that are still queued.

## Interface
- DEPTH, 4: pending-queue capacity in entries; legal values are DEPTH >= 3.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- regwrite_in1, memtoreg_in1  input  1 each  lane-1 (older) controls from MEM/WB.
- readdata_in1, resultalu_in1  input  8 each  lane-1 memory and ALU data.
- rd_in1  input  5  lane-1 destination register.
- regwrite_in2, memtoreg_in2, readdata_in2, resultalu_in2, rd_in2  input  1/1/8/8/5  lane-2 (younger), same meanings as lane 1.
- stall  output  1  hold MEM/WB and all earlier stages; lane inputs are ignored while this is high.
- rf_we  output  1  register-file write enable (registered).
- rf_waddr  output  5  register-file write address (registered).
- rf_wdata  output  8  register-file write data (registered).
- lk_addr  input  5  forwarding lookup address.
- lk_hit  output  1  lk_addr matches a pending or in-flight write (combinational).
- lk_data  output  8  data of the youngest match; 0 when there is no hit.
- occupancy  output  clog2(DEPTH+1)  number of queued entries.

## Operation
- Lane data select: data = memtoreg ? readdata : resultalu.
- Lane valid rule: v = regwrite && rd != 0. Writes to r0 are discarded.
- Accept: acc = !stall.
- Candidate list C, in this order:
  - lane 1, if acc && v1 && !(v2 && rd_in1 == rd_in2). On a same-rd collision the younger lane 2 wins and lane 1 is dropped.
  - lane 2, if acc && v2.
- Stream: S = queue contents (oldest first) followed by C.
- Each rising edge:
  - The first element of S loads {rf_we=1, rf_waddr, rf_wdata}.
  - If S is empty, load rf_we=0, rf_waddr=0, rf_wdata=0.
  - The remainder of S becomes the new queue, and occupancy is updated accordingly.
- Queued entries are never reordered or merged. Repeated writes to the same register are all written in order.
- stall = (occupancy >= DEPTH-1), decoded from registered state only.
- Queue capacity bound: at occupancy = DEPTH-2, two arrivals minus one drain gives DEPTH-1. Occupancy therefore never exceeds DEPTH-1, and no entry is ever lost.
- Lookup priority, youngest first: queue tail toward head, then the rf_* output register (only when rf_we=1).
  - lk_addr = 0 always returns lk_hit=0.
  - Current-cycle lane inputs are not searched.

## Timing
- Reset (asynchronous, reset low) clears all of the following immediately, regardless of the clock:
  - occupancy=0, queue emptied;
  - rf_we=0, rf_waddr=0, rf_wdata=0;
  - stall=0, lk_hit=0, lk_data=0.
  - Any queued writes are discarded.
- Release is synchronous to the first rising edge with reset high.
- Latency:
  - An accepted instruction reaches the rf_* outputs one edge after acceptance if the queue was empty.
  - Otherwise it waits one extra edge per older queued entry.
  - The register file commits on the edge after that.
- Throughput: one register-file write per cycle. Sustained dual writes grow the queue by 1 per cycle until stall asserts.
- Stall behaviour:
  - stall asserts in the cycle in which occupancy reaches DEPTH-1.
  - While stall is high, occupancy drains by 1 per edge.
  - stall deasserts once occupancy < DEPTH-1. Upstream re-presents the held lanes, and they are accepted then.
- Simultaneous events:
  - Queue drain and arrivals in the same edge are handled by the S rule above.
  - regwrite=1 with rd=0 counts as no write.
  - Both lanes invalid while the queue is empty gives rf_we=0.

## Test plan
- Reset mid-operation:
  - Stimulus: fill the queue to occupancy 3 (DEPTH=4), then pull reset low between edges.
  - Required: occupancy=0, rf_we=0 and stall=0 without waiting for a clock edge, and no further writes appear afterwards.
- Single lane:
  - Stimulus: lane 1 with rd=5, memtoreg=1, readdata=0xA5, resultalu=0x11; lane 2 idle.
  - Required: next edge gives rf_we=1, rf_waddr=5, rf_wdata=0xA5; occupancy stays 0.
- Dual write:
  - Stimulus: lane 1 rd=3, ALU 0x10; lane 2 rd=4, ALU 0x20, in one cycle.
  - Required: r3=0x10 is written, then r4=0x20 on the following edge; occupancy goes 1 then 0.
  - Required: while occupancy=1, lk_addr=4 returns lk_hit=1, lk_data=0x20.
- Same-rd collision:
  - Stimulus: both lanes target rd=7, lane 1 with 0x01, lane 2 with 0x02.
  - Required: exactly one write, r7=0x02; occupancy stays 0.
- Stall:
  - Stimulus: present dual valid writes every cycle with DEPTH=4.
  - Required: stall rises once occupancy=3, and lane inputs are ignored while it is high.
  - Required: after occupancy drains to 2, stall drops and the held pair is accepted once. No write is duplicated or lost; check against a scoreboard.
- r0 discard:
  - Stimulus: lane 1 regwrite=1, rd=0, ALU 0xFF; lane 2 idle.
  - Required: rf_we stays 0, occupancy stays 0, and lk_addr=0 returns lk_hit=0.
